// File: rtl/aib_tx_arbiter_pkg.sv
// Shared types, widths and the round-robin pick helper for the AIB TX arbiter.
package aib_arb_pkg;

    localparam int unsigned AIB_FLIT_W = 72;
    localparam int unsigned MAX_REQ    = 16;
    localparam int unsigned MAX_IDX_W  = 4;
    localparam int unsigned CNT_W      = MAX_IDX_W + 1;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    // One-hot grant for the first valid requester at ptr, ptr+1, ... wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   valid,
        input logic [MAX_IDX_W-1:0] ptr,
        input logic [CNT_W-1:0]     n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        logic [CNT_W-1:0]   idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = {1'b0, ptr} + CNT_W'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((CNT_W'(i) < n) && !found && valid[idx[MAX_IDX_W-1:0]]) begin
                gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
                found                   = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/aib_tx_arbiter_if.sv
// Requester-side and adapter-side streams of the AIB TX arbiter.
interface aib_tx_arbiter_if
    import aib_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = AIB_FLIT_W
);
    logic [N_REQ-1:0]        i_req_valid;
    logic [N_REQ-1:0]        o_req_ready;
    logic [N_REQ*DATA_W-1:0] i_req_data;
    logic [N_REQ-1:0]        i_req_last;
    logic                    o_tx_valid;
    logic                    i_tx_ready;
    logic [DATA_W-1:0]       o_tx_data;

    // Arbiter view.
    modport master (
        input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
        output o_req_ready, o_tx_valid, o_tx_data
    );

    // Requesters plus adapter view.
    modport slave (
        output i_req_valid, i_req_data, i_req_last, i_tx_ready,
        input  o_req_ready, o_tx_valid, o_tx_data
    );
endinterface

// File: rtl/aib_skid_fifo2.sv
// Two-entry registered buffer; in_ready depends only on the occupancy flops.
module aib_skid_fifo2
    import aib_arb_pkg::*;
#(
    parameter int unsigned DATA_W = AIB_FLIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              push, pop;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Write/read pointer and occupancy update; simultaneous push and pop keep the count.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = in_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/aib_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the AIB adapter TX stream.
module aib_tx_arbiter
    import aib_arb_pkg::*;
#(
    parameter  int unsigned N_REQ  = 4,
    parameter  int unsigned DATA_W = AIB_FLIT_W,
    localparam int unsigned IDW    = $clog2(N_REQ)
) (
    input  logic                 i_bus_clk,
    input  logic                 i_rst,
    aib_tx_arbiter_if.master     bus,
    output logic                 o_busy,
    output logic [IDW-1:0]       o_grant_id
);
    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    gnt_q, gnt_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    gid_q, gid_d;
    logic [N_REQ-1:0]  pick_oh;
    logic [IDW-1:0]    pick_idx;
    logic [IDW-1:0]    sel_idx;
    logic [N_REQ-1:0]  req_ready_c;
    logic              can_accept;
    logic              accept;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;

    // Round-robin candidate among currently valid requesters.
    always_comb begin
        pick_oh  = N_REQ'(rr_pick(MAX_REQ'(bus.i_req_valid), MAX_IDX_W'(ptr_q), CNT_W'(N_REQ)));
        pick_idx = '0;
        for (int unsigned r = 0; r < N_REQ; r++) begin
            if (pick_oh[r]) begin
                pick_idx = IDW'(r);
            end
        end
    end

    // Grant FSM: pick in IDLE, hold the grantee through its last beat in LOCKED.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        req_ready_c = '0;
        sel_idx     = pick_idx;
        if (state_q == ARB_LOCKED) begin
            sel_idx              = gnt_q;
            req_ready_c[gnt_q]   = can_accept;
        end else if (|bus.i_req_valid) begin
            req_ready_c[pick_idx] = can_accept;
        end
        accept   = |(req_ready_c & bus.i_req_valid);
        sel_last = bus.i_req_last[sel_idx];
        sel_data = bus.i_req_data[sel_idx*DATA_W +: DATA_W];
        if (accept) begin
            gid_d = sel_idx;
            if (sel_last) begin
                state_d = ARB_IDLE;
                ptr_d   = (sel_idx == IDW'(N_REQ - 1)) ? '0 : sel_idx + IDW'(1);
            end else begin
                state_d = ARB_LOCKED;
                gnt_d   = sel_idx;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge i_bus_clk) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
        end
    end

    aib_skid_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk       (i_bus_clk),
        .rst       (i_rst),
        .in_valid  (accept),
        .in_ready  (can_accept),
        .in_data   (sel_data),
        .out_valid (bus.o_tx_valid),
        .out_ready (bus.i_tx_ready),
        .out_data  (bus.o_tx_data)
    );

    assign bus.o_req_ready = req_ready_c;
    assign o_grant_id      = gid_q;
    assign o_busy          = (state_q == ARB_LOCKED) || bus.o_tx_valid;
endmodule

// File: tb/tb_aib_tx_arbiter.sv
// Randomized bench for aib_tx_arbiter with a transaction-level reference model.
module tb_aib_tx_arbiter;
    localparam int N = 4;
    localparam int W = 72;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [1:0] gid;

    aib_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    aib_tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .i_bus_clk  (clk),
        .i_rst      (rst),
        .bus        (bus.master),
        .o_busy     (busy),
        .o_grant_id (gid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Source knobs and per-requester packet progress.
    int pct_new [N];
    int len_lo  [N];
    int len_hi  [N];
    int plen    [N];
    int beat    [N];
    int pktno   [N];
    bit pres    [N];
    int pct_mid;
    int pct_rdy;

    // Reference model: lock/grantee/pointer, buffered beats, grant history.
    bit             m_lock;
    int             m_g;
    int             m_ptr;
    int             m_gid;
    logic [W-1:0]   mq[$];
    int             acc_log[$];
    int             dut_acc_cnt;
    bit             chk_en;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_idle();
        bit idle;
        idle = !m_lock && (mq.size() == 0);
        for (int r = 0; r < N; r++) begin
            if (pres[r] || beat[r] != 0) idle = 0;
        end
        return idle;
    endfunction

    task automatic model_reset();
        m_lock = 0;
        m_g    = 0;
        m_ptr  = 0;
        m_gid  = 0;
        mq.delete();
        for (int r = 0; r < N; r++) begin
            pres[r] = 0;
            beat[r] = 0;
        end
    endtask

    // One clock: drive at edge+1, check at the falling edge, advance the model at the edge.
    task automatic step(input bit do_rst);
        logic [N-1:0] exp_rdy;
        int           sel;
        int           rr;
        bit           go;
        bit           pop;
        rst = do_rst;
        for (int r = 0; r < N; r++) begin
            if (do_rst) begin
                pres[r] = 0;
            end else if (!pres[r]) begin
                if (beat[r] == 0) go = ($urandom_range(99) < pct_new[r]);
                else              go = ($urandom_range(99) < pct_mid);
                if (go) begin
                    if (beat[r] == 0) plen[r] = $urandom_range(len_hi[r], len_lo[r]);
                    pres[r] = 1;
                    bus.i_req_data[r*W +: W] = {8'(r), 16'(pktno[r]), 16'(beat[r]), 32'($urandom)};
                    bus.i_req_last[r]        = (beat[r] == plen[r] - 1);
                end
            end
            bus.i_req_valid[r] = pres[r];
        end
        bus.i_tx_ready = ($urandom_range(99) < pct_rdy);
        #4;
        exp_rdy = '0;
        sel     = -1;
        if (mq.size() < 2) begin
            if (m_lock) begin
                sel          = m_g;
                exp_rdy[m_g] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    rr = (m_ptr + k) % N;
                    if (sel < 0 && bus.i_req_valid[rr]) begin
                        sel         = rr;
                        exp_rdy[rr] = 1'b1;
                    end
                end
            end
        end
        if (chk_en) begin
            check_eq("req_ready", W'(bus.o_req_ready), W'(exp_rdy));
            check_eq("tx_valid", W'(bus.o_tx_valid), W'(mq.size() != 0));
            if (mq.size() != 0) check_eq("tx_data", bus.o_tx_data, mq[0]);
            check_eq("busy", W'(busy), W'(m_lock || mq.size() != 0));
            check_eq("grant_id", W'(gid), W'(m_gid));
        end
        if (|(bus.o_req_ready & bus.i_req_valid)) dut_acc_cnt++;
        pop = (mq.size() != 0) && bus.i_tx_ready;
        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else begin
            if (pop) void'(mq.pop_front());
            if ((exp_rdy & bus.i_req_valid) != '0) begin
                mq.push_back(bus.i_req_data[sel*W +: W]);
                m_gid   = sel;
                pres[sel] = 0;
                acc_log.push_back(sel);
                if (bus.i_req_last[sel]) begin
                    m_lock     = 0;
                    m_ptr      = (sel + 1) % N;
                    beat[sel]  = 0;
                    pktno[sel] = pktno[sel] + 1;
                end else begin
                    m_lock    = 1;
                    m_g       = sel;
                    beat[sel] = beat[sel] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic set_all(input int pnew, input int llo, input int lhi);
        for (int r = 0; r < N; r++) begin
            pct_new[r] = pnew;
            len_lo[r]  = llo;
            len_hi[r]  = lhi;
        end
    endtask

    // Let every open packet finish and the buffer empty, bounded.
    task automatic drain();
        set_all(0, 1, 1);
        pct_mid = 100;
        pct_rdy = 100;
        for (int i = 0; i < 200 && !model_idle(); i++) step(0);
        step(0);
        check_eq("drain_done", W'(model_idle()), W'(1));
        check_eq("drain_busy", W'(busy), W'(0));
    endtask

    initial begin
        int occ0;
        bus.i_req_valid = '0;
        bus.i_req_last  = '0;
        bus.i_req_data  = '0;
        bus.i_tx_ready  = 1'b0;
        rst         = 1'b1;
        chk_en      = 0;
        dut_acc_cnt = 0;
        pct_mid     = 100;
        pct_rdy     = 100;
        set_all(0, 1, 1);
        for (int r = 0; r < N; r++) pktno[r] = 0;
        model_reset();
        @(posedge clk);
        #1;
        step(1);
        step(1);
        chk_en = 1;

        // Reset state, idle for 10 cycles.
        check_eq("rst_tx_data", bus.o_tx_data, W'(0));
        check_eq("rst_tx_valid", W'(bus.o_tx_valid), W'(0));
        check_eq("rst_grant_id", W'(gid), W'(0));
        repeat (10) step(0);

        // All requesters streaming single-beat packets at full rate.
        set_all(100, 1, 1);
        acc_log.delete();
        repeat (16) step(0);
        check_eq("t2_rate", W'(acc_log.size()), W'(16));
        if (acc_log.size() >= 8)
            for (int i = 0; i < 8; i++) check_eq("t2_order", W'(acc_log[i]), W'(i % N));

        // Three-beat packet from req1 blocks req2 until its last beat.
        drain();
        len_lo[1] = 3; len_hi[1] = 3;
        acc_log.delete();
        pct_new[1] = 100;
        step(0);
        pct_new[1] = 0;
        pct_new[2] = 100;
        repeat (6) step(0);
        check_eq("t3_cnt", W'(acc_log.size() >= 4), W'(1));
        if (acc_log.size() >= 4) begin
            check_eq("t3_b0", W'(acc_log[0]), W'(1));
            check_eq("t3_b1", W'(acc_log[1]), W'(1));
            check_eq("t3_b2", W'(acc_log[2]), W'(1));
            check_eq("t3_next", W'(acc_log[3]), W'(2));
        end

        // Adapter stall mid-stream: buffer fills to two, then no ready.
        set_all(100, 1, 1);
        repeat (4) step(0);
        occ0        = mq.size();
        pct_rdy     = 0;
        dut_acc_cnt = 0;
        repeat (5) step(0);
        check_eq("t4_stall_acc", W'(dut_acc_cnt), W'(2 - occ0));
        check_eq("t4_ready_off", W'(bus.o_req_ready), W'(0));
        pct_rdy = 100;
        repeat (8) step(0);

        // Locked req0 bubbles for 3 cycles; req3 must wait for req0's last beat.
        drain();
        len_lo[0] = 4; len_hi[0] = 4;
        acc_log.delete();
        pct_new[0] = 100;
        step(0);
        pct_new[0] = 0;
        pct_new[3] = 100;
        pct_mid    = 0;
        repeat (3) step(0);
        pct_mid = 100;
        repeat (8) step(0);
        check_eq("t5_cnt", W'(acc_log.size() >= 5), W'(1));
        if (acc_log.size() >= 5) begin
            for (int i = 0; i < 4; i++) check_eq("t5_req0", W'(acc_log[i]), W'(0));
            check_eq("t5_req3", W'(acc_log[4]), W'(3));
        end

        // Reset mid-packet with two beats buffered.
        drain();
        len_lo[0] = 5; len_hi[0] = 5;
        pct_new[0] = 100;
        pct_rdy    = 0;
        repeat (3) step(0);
        check_eq("t6_full_busy", W'(busy), W'(1));
        step(1);
        check_eq("t6_txv_after_rst", W'(bus.o_tx_valid), W'(0));
        check_eq("t6_busy_after_rst", W'(busy), W'(0));
        set_all(100, 1, 1);
        pct_rdy = 100;
        acc_log.delete();
        repeat (8) step(0);
        check_eq("t6_cnt", W'(acc_log.size() >= 1), W'(1));
        if (acc_log.size() >= 1) check_eq("t6_first", W'(acc_log[0]), W'(0));

        // Long random run with changing traffic mixes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                for (int r = 0; r < N; r++) begin
                    pct_new[r] = $urandom_range(100);
                    len_lo[r]  = 1;
                    len_hi[r]  = $urandom_range(5, 1);
                end
                pct_mid = $urandom_range(100, 30);
                pct_rdy = $urandom_range(100, 20);
            end
            step($urandom_range(299) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
